trivium_session_ctrl: RTL and testbench

Session controller that sequences the Trivium keystream core between the UART byte receiver and transmitter. It collects a 10-byte key and a 10-byte IV from the incoming byte stream, then loads the core and runs the warm-up. Afterwards it encrypts each received byte by stepping the core 8 times and XORing the keystream bits, and hands the result to the UART transmitter. It sits between the UART RX/TX byte interfaces and the Trivium core inside the top-level serial wrapper.

---
 rtl/trivium_session_ctrl.sv | 170 +++++++++++++++++
 tb/tb_trivium_session_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/trivium_session_ctrl.sv
// Session controller between the UART byte interfaces and the Trivium core.
// It collects a 10-byte key and a 10-byte IV, loads the core, runs the warm-up,
// then encrypts each received byte with 8 keystream bits and hands it to the TX.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   rx_data/rx_valid     byte strobe from the UART receiver
//   tx_data/tx_valid     ciphertext byte to the UART transmitter, held until tx_ready
//   tx_ready             transmitter accepts when tx_valid & tx_ready
//   core_key/core_iv     80-bit key/IV to the core, byte n at bits [8n+7:8n]
//   core_init            one-cycle load pulse to the core
//   core_en              core step enable
//   core_z               keystream bit of the current core state
//   state_o              current state (KEY=0 .. SEND=6)
//   overrun              sticky flag: a byte arrived while busy and was dropped
module trivium_session_ctrl #(
  parameter int unsigned WARMUP = 1152
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [79:0] core_key,
  output logic [79:0] core_iv,
  output logic        core_init,
  output logic        core_en,
  input  logic        core_z,
  output logic [2:0]  state_o,
  output logic        overrun
);

  localparam int unsigned NBYTES = 10;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  typedef enum logic [2:0] {
    S_KEY  = 3'd0,
    S_IV   = 3'd1,
    S_INIT = 3'd2,
    S_WARM = 3'd3,
    S_RUN  = 3'd4,
    S_GEN  = 3'd5,
    S_SEND = 3'd6
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WARM_W-1:0]  wcnt_q;
  logic [2:0]         bit_q;
  logic [7:0]         pt_q;
  logic [7:0]         ct_q;
  logic [7:0]         ct_d;
  logic [79:0]        key_q;
  logic [79:0]        iv_q;
  logic               init_q;
  logic               en_q;
  logic               txv_q;
  logic [7:0]         txd_q;
  logic               ovr_q;

  // Ciphertext with the current step's keystream bit folded into position bit_q.
  always_comb begin
    ct_d        = ct_q;
    ct_d[bit_q] = pt_q[bit_q] ^ core_z;
  end

  // Session FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_KEY;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      bit_q   <= '0;
      pt_q    <= '0;
      ct_q    <= '0;
      key_q   <= '0;
      iv_q    <= '0;
      init_q  <= 1'b0;
      en_q    <= 1'b0;
      txv_q   <= 1'b0;
      txd_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      init_q <= 1'b0;
      case (state_q)
        S_KEY: begin
          if (rx_valid) begin
            key_q[{cnt_q, 3'b000} +: 8] <= rx_data;
            if (cnt_q == CNT_W'(NBYTES - 1)) begin
              cnt_q   <= '0;
              state_q <= S_IV;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        S_IV: begin
          if (rx_valid) begin
            iv_q[{cnt_q, 3'b000} +: 8] <= rx_data;
            if (cnt_q == CNT_W'(NBYTES - 1)) begin
              cnt_q   <= '0;
              init_q  <= 1'b1;
              state_q <= S_INIT;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        S_INIT: begin
          // Enable rises the cycle after the load pulse so the two never overlap.
          en_q    <= 1'b1;
          wcnt_q  <= '0;
          state_q <= S_WARM;
          if (rx_valid) ovr_q <= 1'b1;
        end
        S_WARM: begin
          if (wcnt_q == WARM_W'(WARMUP - 1)) begin
            en_q    <= 1'b0;
            state_q <= S_RUN;
          end else begin
            wcnt_q <= wcnt_q + WARM_W'(1);
          end
          if (rx_valid) ovr_q <= 1'b1;
        end
        S_RUN: begin
          if (rx_valid) begin
            pt_q    <= rx_data;
            ct_q    <= '0;
            bit_q   <= '0;
            en_q    <= 1'b1;
            state_q <= S_GEN;
          end
        end
        S_GEN: begin
          ct_q <= ct_d;
          if (bit_q == 3'd7) begin
            en_q    <= 1'b0;
            txv_q   <= 1'b1;
            txd_q   <= ct_d;
            state_q <= S_SEND;
          end else begin
            bit_q <= bit_q + 3'd1;
          end
          if (rx_valid) ovr_q <= 1'b1;
        end
        S_SEND: begin
          if (tx_ready) begin
            txv_q   <= 1'b0;
            state_q <= S_RUN;
          end
          // A byte arriving on the transfer cycle itself is still dropped.
          if (rx_valid) ovr_q <= 1'b1;
        end
        default: state_q <= S_KEY;
      endcase
    end
  end

  assign tx_data   = txd_q;
  assign tx_valid  = txv_q;
  assign core_key  = key_q;
  assign core_iv   = iv_q;
  assign core_init = init_q;
  assign core_en   = en_q;
  assign state_o   = state_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_trivium_session_ctrl.sv
// Bench for trivium_session_ctrl with a stand-in core whose keystream
// alternates 1,0,1,0... after warm-up. Expected ciphertext goes into a queue;
// a monitor pops and compares on every tx handshake.
module tb_trivium_session_ctrl;
  localparam int unsigned WARMUP = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [79:0] core_key;
  logic [79:0] core_iv;
  logic        core_init;
  logic        core_en;
  logic        core_z;
  logic [2:0]  state_o;
  logic        overrun;

  int checks   = 0;
  int failures = 0;
  int xfers    = 0;
  int steps    = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  trivium_session_ctrl #(.WARMUP(WARMUP)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .core_key(core_key), .core_iv(core_iv),
    .core_init(core_init), .core_en(core_en), .core_z(core_z),
    .state_o(state_o), .overrun(overrun)
  );

  // Stand-in core: counts steps since load; keystream 1,0,1,0... after warm-up.
  always @(posedge clk) begin
    if (core_init) steps <= 0;
    else if (core_en) steps <= steps + 1;
  end
  assign core_z = (steps >= int'(WARMUP)) && (((steps - int'(WARMUP)) % 2) == 0);

  // Scoreboard monitor on the tx handshake.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      logic [7:0] e;
      xfers++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL tx_unexpected: got %02h with nothing expected", tx_data);
      end else begin
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          failures++;
          $display("FAIL tx_data: got %02h expected %02h", tx_data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_run(input string name);
    int n = 0;
    while (state_o !== 3'd4 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 60) begin
      failures++;
      $display("FAIL %s_timeout: state %0d after %0d cycles, expected 4", name, state_o, n);
    end
  endtask

  task automatic encrypt(input logic [7:0] b, input logic [7:0] e);
    exp_q.push_back(e);
    drive_byte(b);
    wait_run("encrypt");
  endtask

  task automatic load_keys(input bit warm_strobe);
    int n = 0;
    int en_cnt = 0;
    for (int i = 0; i < 10; i++) drive_byte(8'(i + 1));
    for (int i = 0; i < 10; i++) drive_byte(8'hA0 + 8'(i));
    chk("init_pulse", 80'(core_init), 80'd1);
    chk("init_no_en", 80'(core_en), 80'd0);
    while (state_o !== 3'd4 && n < 100) begin
      tick();
      n++;
      if (core_en) en_cnt++;
      if (warm_strobe && n == 5) begin
        rx_data  = 8'hEE;
        rx_valid = 1'b1;
      end else begin
        rx_valid = 1'b0;
      end
    end
    rx_valid = 1'b0;
    chk("core_key", core_key, 80'h0A09_0807_0605_0403_0201);
    chk("core_iv", core_iv, 80'hA9A8_A7A6_A5A4_A3A2_A1A0);
    chk("warm_en_cycles", 80'(en_cnt), 80'd16);
    chk("run_latency", 80'(n), 80'd17);
    chk("run_state", 80'(state_o), 80'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int x0;
    logic [7:0] seq [10];
    seq = '{8'hA5, 8'h3C, 8'h7F, 8'hC1, 8'h99, 8'h42, 8'hE7, 8'hB8, 8'h5D, 8'hF0};
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    tick(); tick();
    chk("rst_state", 80'(state_o), 80'd0);
    chk("rst_key", core_key, 80'd0);
    chk("rst_iv", core_iv, 80'd0);
    chk("rst_init", 80'(core_init), 80'd0);
    chk("rst_en", 80'(core_en), 80'd0);
    chk("rst_tx_valid", 80'(tx_valid), 80'd0);
    chk("rst_tx_data", 80'(tx_data), 80'd0);
    chk("rst_overrun", 80'(overrun), 80'd0);
    rst = 1'b0;

    load_keys(1'b0);
    encrypt(8'h00, 8'h55);
    encrypt(8'hFF, 8'hAA);

    // Backpressure: 0x5A ^ 0x55 = 0x0F held for 5 cycles.
    tx_ready = 1'b0;
    exp_q.push_back(8'h0F);
    drive_byte(8'h5A);
    x0 = xfers;
    n = 0;
    while (!tx_valid && n < 20) begin tick(); n++; end
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 80'(tx_valid), 80'd1);
      chk("bp_data", 80'(tx_data), 80'h0F);
      chk("bp_no_en", 80'(core_en), 80'd0);
      tick();
    end
    tx_ready = 1'b1;
    wait_run("backpressure");
    chk("bp_one_xfer", 80'(xfers - x0), 80'd1);

    // Overrun during GEN: 0x3C ^ 0x55 = 0x69, 0x11 is dropped.
    chk("ovr_clear", 80'(overrun), 80'd0);
    exp_q.push_back(8'h69);
    drive_byte(8'h3C);
    drive_byte(8'h11);
    chk("ovr_gen", 80'(overrun), 80'd1);
    wait_run("ovr_gen");
    encrypt(8'h00, 8'h55);
    chk("ovr_sticky", 80'(overrun), 80'd1);

    // Reset in the middle of GEN.
    drive_byte(8'h77);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("midgen_en", 80'(core_en), 80'd0);
    chk("midgen_txv", 80'(tx_valid), 80'd0);
    chk("midgen_state", 80'(state_o), 80'd0);
    tick();
    chk("midgen_ovr", 80'(overrun), 80'd0);
    chk("midgen_key", core_key, 80'd0);
    rst = 1'b0;

    // Overrun during WARM: warm-up length unaffected. 0xC3 ^ 0x55 = 0x96.
    load_keys(1'b1);
    chk("ovr_warm", 80'(overrun), 80'd1);
    encrypt(8'hC3, 8'h96);

    // Fresh session, 10-byte stream; alternating keystream gives 0x55 per byte.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    load_keys(1'b0);
    for (int i = 0; i < 10; i++) encrypt(seq[i], seq[i] ^ 8'h55);
    chk("seq_overrun", 80'(overrun), 80'd0);
    chk("sb_drained", 80'(exp_q.size()), 80'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
